// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: iterative restoring floating-point square root with ready/valid input and special-operand fast path.
// Define FP_SQRT_ROUND_EN for round-to-nearest-even; otherwise the root is truncated.
module fp_sqrt_iter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic [EXP_W+MAN_W:0]   n,
  input  logic                   data_valid_in,
  output logic                   ready_out,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   data_valid_out,
  output logic                   invalid_out
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 2;
  localparam int RW    = 2 * N + 2;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(N - 1);
  localparam logic [EXP_W-1:0] HALF_B = EXP_W'((1 << (EXP_W - 2)) - 1);
  localparam logic [W-1:0]     NAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0]     INF    = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_SQRT_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACTIVE, ROUND} state_t;

  state_t            state_q, state_d;
  logic [2*N-1:0]    x_q, x_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [N-1:0]      root_q, root_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EXP_W-1:0]  exp_r_q, exp_r_d;
  logic [W-1:0]      res_q, res_d, sp_res_q, sp_res_d;
  logic              dv_q, dv_d, inv_q, inv_d, sp_pend_q, sp_pend_d, sp_inv_q, sp_inv_d;

  logic              sgn, exp_max, exp_zero, frac_zero, special, spec_inv;
  logic [EXP_W-1:0]  ex;
  logic [MAN_W-1:0]  fr;
  logic [W-1:0]      spec_res;
  logic [N-1:0]      mant;
  logic [EXP_W-1:0]  exp_start;
  logic [RW-1:0]     rem_sh, trial;
  logic              trial_ok, rnd;
  logic [MAN_W:0]    frac_sum;

  assign sgn       = n[W-1];
  assign ex        = n[W-2:MAN_W];
  assign fr        = n[MAN_W-1:0];
  assign exp_max   = &ex;
  assign exp_zero  = ~|ex;
  assign frac_zero = ~|fr;
  assign special   = exp_zero | exp_max | sgn;
  assign spec_res  = exp_zero ? {sgn, {(W-1){1'b0}}} :
                     (exp_max & frac_zero & ~sgn) ? INF : NAN;
  assign spec_inv  = exp_zero ? 1'b0 : exp_max ? (frac_zero ? sgn : ~fr[MAN_W-1]) : 1'b1;
  // Odd biased exponent means even unbiased exponent, so the mantissa is used as-is.
  assign mant      = ex[0] ? {1'b0, 1'b1, fr} : {1'b1, fr, 1'b0};
  assign exp_start = {1'b0, ex[EXP_W-1:1]} + HALF_B + {{(EXP_W-1){1'b0}}, ex[0]};

  assign rem_sh    = {rem_q[RW-3:0], x_q[2*N-1 -: 2]};
  assign trial     = {{N{1'b0}}, root_q, 2'b01};
  assign trial_ok  = rem_sh >= trial;

  assign rnd       = ROUND_EN & root_q[0] & ((|rem_q) | root_q[1]);
  assign frac_sum  = {1'b0, root_q[N-2:1]} + {{MAN_W{1'b0}}, rnd};

  assign ready_out      = state_q == IDLE;
  assign result         = res_q;
  assign data_valid_out = dv_q;
  assign invalid_out    = inv_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    exp_r_d   = exp_r_q;
    res_d     = sp_pend_q ? sp_res_q : res_q;
    inv_d     = sp_pend_q ? sp_inv_q : inv_q;
    dv_d      = sp_pend_q;
    sp_pend_d = 1'b0;
    sp_res_d  = sp_res_q;
    sp_inv_d  = sp_inv_q;
    case (state_q)
      IDLE: begin
        if (data_valid_in && special) begin
          sp_pend_d = 1'b1;
          sp_res_d  = spec_res;
          sp_inv_d  = spec_inv;
        end else if (data_valid_in) begin
          state_d = ACTIVE;
          x_d     = {mant, {N{1'b0}}};
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          exp_r_d = exp_start;
        end
      end
      ACTIVE: begin
        rem_d   = trial_ok ? rem_sh - trial : rem_sh;
        root_d  = {root_q[N-2:0], trial_ok};
        x_d     = x_q << 2;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = cnt_q == LAST ? ROUND : ACTIVE;
      end
      ROUND: begin
        res_d   = {1'b0, exp_r_q + {{(EXP_W-1){1'b0}}, frac_sum[MAN_W]}, frac_sum[MAN_W-1:0]};
        inv_d   = 1'b0;
        dv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      exp_r_q   <= '0;
      res_q     <= '0;
      dv_q      <= 1'b0;
      inv_q     <= 1'b0;
      sp_pend_q <= 1'b0;
      sp_res_q  <= '0;
      sp_inv_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      exp_r_q   <= exp_r_d;
      res_q     <= res_d;
      dv_q      <= dv_d;
      inv_q     <= inv_d;
      sp_pend_q <= sp_pend_d;
      sp_res_q  <= sp_res_d;
      sp_inv_q  <= sp_inv_d;
    end
  end
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: directed checks of the binary16 and binary32 square-root builds.
module tb_fp_sqrt_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] n16, res16;
  logic        v16, rdy16, dv16, inv16;
  logic [31:0] n32, res32;
  logic        v32, rdy32, dv32, inv32;
  int errors = 0;
  int checks = 0;

`ifdef FP_SQRT_ROUND_EN
  localparam logic [15:0] SQRT3 = 16'h3EEE;
`else
  localparam logic [15:0] SQRT3 = 16'h3EED;
`endif

  fp_sqrt_iter dut16 (
    .clk_in(clk), .rst_n(rst_n), .n(n16), .data_valid_in(v16), .ready_out(rdy16),
    .result(res16), .data_valid_out(dv16), .invalid_out(inv16)
  );

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk_in(clk), .rst_n(rst_n), .n(n32), .data_valid_in(v32), .ready_out(rdy32),
    .result(res32), .data_valid_out(dv32), .invalid_out(inv32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic op(input bit wide, input logic [31:0] a, input logic [31:0] want,
                    input logic want_inv, input int want_lat, input string tag);
    int lat;
    int g;
    @(negedge clk);
    g = 0;
    while (!(wide ? rdy32 : rdy16) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (wide) begin n32 = a; v32 = 1'b1; end
    else begin n16 = a[15:0]; v16 = 1'b1; end
    @(posedge clk);
    #1 v16 = 1'b0;
    v32 = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      if (wide ? dv32 : dv16) break;
    end
    check({tag, "_lat"}, lat, want_lat);
    check({tag, "_res"}, wide ? res32 : {16'h0, res16}, want);
    check({tag, "_inv"}, {31'h0, wide ? inv32 : inv16}, {31'h0, want_inv});
  endtask

  initial begin
    int pulses;
    int p1_lat, p2_lat;
    logic [15:0] p1_res, p2_res;
    n16 = '0; v16 = 1'b0; n32 = '0; v32 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, rdy16}, 32'd1);
    check("rst_dv", {31'h0, dv16}, 32'd0);
    check("rst_res", {16'h0, res16}, 32'h0);
    check("rst_inv", {31'h0, inv16}, 32'd0);
    rst_n = 1'b1;

    op(1'b0, 32'h4400, 32'h4000, 1'b0, 13, "sqrt4");
    op(1'b0, 32'h3C00, 32'h3C00, 1'b0, 13, "sqrt1");
    op(1'b0, 32'h0000, 32'h0000, 1'b0, 1, "zero");
    op(1'b0, 32'h4200, {16'h0, SQRT3}, 1'b0, 13, "sqrt3");
    op(1'b0, 32'h4000, 32'h3DA8, 1'b0, 13, "sqrt2");
    op(1'b0, 32'h7BFF, 32'h5BFF, 1'b0, 13, "max");
    op(1'b0, 32'hBC00, 32'h7E00, 1'b1, 1, "neg1");
    op(1'b0, 32'h8000, 32'h8000, 1'b0, 1, "negzero");
    op(1'b0, 32'h7C00, 32'h7C00, 1'b0, 1, "pinf");
    op(1'b0, 32'hFC00, 32'h7E00, 1'b1, 1, "ninf");
    op(1'b0, 32'h7D00, 32'h7E00, 1'b1, 1, "snan");
    op(1'b0, 32'h7E00, 32'h7E00, 1'b0, 1, "qnan");
    op(1'b0, 32'h0001, 32'h0000, 1'b0, 1, "subnorm");

    // back-to-back specials, one per cycle
    @(negedge clk);
    n16 = 16'hBC00; v16 = 1'b1;
    @(posedge clk);
    #1 n16 = 16'h8000;
    check("b2b_ready", {31'h0, rdy16}, 32'd1);
    @(posedge clk);
    #1 v16 = 1'b0;
    check("b2b0_dv", {31'h0, dv16}, 32'd1);
    check("b2b0_res", {16'h0, res16}, 32'h7E00);
    check("b2b0_inv", {31'h0, inv16}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b1_dv", {31'h0, dv16}, 32'd1);
    check("b2b1_res", {16'h0, res16}, 32'h8000);
    check("b2b1_inv", {31'h0, inv16}, 32'd0);

    // valid held high: second operand only taken once the first completes
    @(negedge clk);
    n16 = 16'h4400; v16 = 1'b1;
    @(posedge clk);
    #1 n16 = 16'h4200;
    pulses = 0; p1_lat = 0; p2_lat = 0; p1_res = '0; p2_res = '0;
    for (int i = 1; i <= 27; i++) begin
      @(posedge clk);
      #1;
      if (dv16) begin
        pulses++;
        if (pulses == 1) begin p1_lat = i; p1_res = res16; end
        if (pulses == 2) begin p2_lat = i; p2_res = res16; end
      end
    end
    v16 = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1 if (dv16) pulses++;
    end
    check("held_pulses", pulses, 2);
    check("held_lat1", p1_lat, 13);
    check("held_res1", {16'h0, p1_res}, 32'h4000);
    check("held_lat2", p2_lat, 27);
    check("held_res2", {16'h0, p2_res}, {16'h0, SQRT3});

    // reset in the middle of an iteration
    @(negedge clk);
    n16 = 16'h4400; v16 = 1'b1;
    @(posedge clk);
    #1 v16 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("mrst_ready", {31'h0, rdy16}, 32'd1);
    check("mrst_res", {16'h0, res16}, 32'h0);
    check("mrst_dv", {31'h0, dv16}, 32'd0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (dv16) pulses++;
    end
    check("mrst_pulses", pulses, 0);
    op(1'b0, 32'h4400, 32'h4000, 1'b0, 13, "post_rst");

    op(1'b1, 32'h40800000, 32'h40000000, 1'b0, 26, "s_sqrt4");
    op(1'b1, 32'h40000000, 32'h3FB504F3, 1'b0, 26, "s_sqrt2");
    op(1'b1, 32'hBF800000, 32'h7FC00000, 1'b1, 1, "s_neg1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
